// File: rtl/led_blinker.sv
// led_blinker: four toggle generators (c100/c50/c10/c1 clocks per half-period), {i_switch_1,i_switch_2} picks one, i_enable gates it onto o_led_drive; dbg_* ports exist only under LED_BLINKER_DBG_EN
module led_blinker #(
  parameter int c100 = 125000,
  parameter int c50  = 250000,
  parameter int c10  = 1250000,
  parameter int c1   = 12500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_switch_1,
  input  logic i_switch_2,
  output logic o_led_drive
`ifdef LED_BLINKER_DBG_EN
  ,
  output logic dbg_t100,
  output logic dbg_t50,
  output logic dbg_t10,
  output logic dbg_t1,
  output logic dbg_temp_o_led
`endif
);
  localparam int cs [4] = '{c100, c50, c10, c1};
  logic [3:0] t;
  logic temp_o_led;
  for (genvar g = 0; g < 4; g++) begin : gen
    localparam int c = cs[g];
    localparam int w = $clog2(c);
    logic [w-1:0] cnt;
    logic tog;
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        cnt <= '0;
        tog <= 1'b0;
      end else if (cnt == w'(c - 1)) begin
        cnt <= '0;
        tog <= ~tog;
      end else begin
        cnt <= cnt + w'(1);
      end
    end
    assign t[g] = tog;
  end
  always_comb temp_o_led = t[{i_switch_1, i_switch_2}];
  assign o_led_drive = temp_o_led & i_enable;
`ifdef LED_BLINKER_DBG_EN
  assign dbg_t100 = t[0];
  assign dbg_t50 = t[1];
  assign dbg_t10 = t[2];
  assign dbg_t1 = t[3];
  assign dbg_temp_o_led = temp_o_led;
`endif
endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: scoreboard bench; stimulus pushes closed-form expected waves, negedge monitor pops and compares
module tb_led_blinker;
  localparam int c [4] = '{10, 20, 50, 100};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
  logic led;
  logic [4:0] dbg;
`ifdef LED_BLINKER_DBG_EN
  logic d100, d50, d10, d1, dtmp;
  assign dbg = {d100, d50, d10, d1, dtmp};
`else
  assign dbg = '0;
`endif
  always #20 clk = ~clk;
  led_blinker #(.c100(10), .c50(20), .c10(50), .c1(100)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_enable(en),
    .i_switch_1(sw1),
    .i_switch_2(sw2),
    .o_led_drive(led)
`ifdef LED_BLINKER_DBG_EN
    ,
    .dbg_t100(d100),
    .dbg_t50(d50),
    .dbg_t10(d10),
    .dbg_t1(d1),
    .dbg_temp_o_led(dtmp)
`endif
  );
  typedef struct {
    logic led;
    logic [4:0] dbg;
    int k;
    int s;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, k = 0;
  task automatic step(input logic r, input logic e, input int s);
    exp_t x;
    logic [3:0] tv;
    @(posedge clk);
    k = rst ? 0 : k + 1;
    #1;
    rst = r;
    en = e;
    {sw1, sw2} = 2'(s);
    for (int i = 0; i < 4; i++) tv[i] = ((k / c[i]) % 2) == 1;
    x.k = k;
    x.s = s;
    x.led = tv[s] & e;
    x.dbg = {tv[0], tv[1], tv[2], tv[3], tv[s]};
    q.push_back(x);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led k=%0d sel=%0d got %b want %b", e.k, e.s, led, e.led);
        end
`ifdef LED_BLINKER_DBG_EN
        checks++;
        if (dbg !== e.dbg) begin
          errors++;
          $display("FAIL dbg k=%0d sel=%0d got %b want %b", e.k, e.s, dbg, e.dbg);
        end
`endif
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (400) step(0, 0, 0);
    for (int s = 0; s < 4; s++) repeat (100) step(0, 1, s);
    repeat (50) step(0, 0, 0);
    repeat (100) step(0, 1, 3);
    step(1, 1, 3);
    step(0, 1, 3);
    repeat (120) step(0, 1, 3);
    repeat (60) step(0, 1, 0);
    repeat (40) step(0, 1, 1);
    for (int i = 0; i < 40; i++) step(0, 1, (i * 3) % 4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
